hls_run_sequencer: RTL

Synthesizable run controller for an HLS-generated accelerator exposing a `start_port` / `done_port` interface. It replaces per-run testbench sequencing with on-chip hardware and executes a campaign of back-to-back runs. For each run it:

- holds the DUT in reset,
- pulses start,
- counts cycles to done,
- samples a pass/fail flag,
- applies a timeout watchdog,
- reports one result record per run over a valid/ready handshake.

It sits between the DUT top and the board-level result collector.

---
 rtl/hls_run_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hls_run_sequencer.sv
// Run sequencer for an HLS accelerator: resets, starts and times each run of a campaign,
// then reports one result record per run over a valid/ready handshake.
module hls_run_sequencer #(
    parameter int unsigned RUN_W      = 8,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned TIMEOUT    = 200000000,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [RUN_W-1:0] num_runs,
    output logic             dut_reset,
    output logic             dut_start_port,
    input  logic             dut_done_port,
    input  logic             dut_check,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_status,
    output logic [CNT_W-1:0] res_cycles,
    output logic [RUN_W-1:0] res_run,
    output logic             busy,
    output logic             campaign_done,
    output logic [RUN_W-1:0] pass_count
);

    localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]  RcLast     = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

    localparam logic [1:0] StatPass    = 2'b00;
    localparam logic [1:0] StatFail    = 2'b01;
    localparam logic [1:0] StatTimeout = 2'b10;

    typedef enum logic [2:0] {StIdle, StDutRst, StStart, StWait, StReport} state_e;

    state_e           state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] idx_q, idx_d;
    logic [RUN_W-1:0] runs_q, runs_d;
    logic [1:0]       status_q, status_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [RUN_W-1:0] pass_q, pass_d;
    logic             cdone_q, cdone_d;
    logic             dut_reset_q;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        runs_d    = runs_q;
        status_d  = status_q;
        cycles_d  = cycles_q;
        pass_d    = pass_q;
        cdone_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (go) begin
                    if (num_runs != '0) begin
                        runs_d    = num_runs;
                        idx_d     = '0;
                        pass_d    = '0;
                        rst_cnt_d = '0;
                        state_d   = StDutRst;
                    end else begin
                        cdone_d = 1'b1;
                    end
                end
            end
            StDutRst: begin
                // dut_done_port is deliberately ignored: a stale level from the last run is masked
                if (rst_cnt_q == RcLast) begin
                    state_d = StStart;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            StStart: begin
                if (dut_done_port) begin
                    status_d = dut_check ? StatPass : StatFail;
                    cycles_d = CNT_W'(1);
                    state_d  = StReport;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = StWait;
                end
            end
            StWait: begin
                // Done takes priority over a timeout landing in the same cycle
                if (dut_done_port) begin
                    status_d = dut_check ? StatPass : StatFail;
                    cycles_d = cnt_q + CNT_W'(1);
                    state_d  = StReport;
                end else if (cnt_q == TimeoutVal) begin
                    status_d = StatTimeout;
                    cycles_d = TimeoutVal;
                    state_d  = StReport;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StReport: begin
                if (res_ready) begin
                    if (status_q == StatPass) begin
                        pass_d = pass_q + RUN_W'(1);
                    end
                    if (idx_q == runs_q - RUN_W'(1)) begin
                        cdone_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d     = idx_q + RUN_W'(1);
                        rst_cnt_d = '0;
                        state_d   = StDutRst;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            rst_cnt_q   <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            runs_q      <= '0;
            status_q    <= StatPass;
            cycles_q    <= '0;
            pass_q      <= '0;
            cdone_q     <= 1'b0;
            dut_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            runs_q      <= runs_d;
            status_q    <= status_d;
            cycles_q    <= cycles_d;
            pass_q      <= pass_d;
            cdone_q     <= cdone_d;
            dut_reset_q <= (state_d != StDutRst);
        end
    end

    assign dut_reset      = dut_reset_q;
    assign dut_start_port = (state_q == StStart);
    assign res_valid      = (state_q == StReport);
    assign busy           = (state_q != StIdle);
    assign res_status     = status_q;
    assign res_cycles     = cycles_q;
    assign res_run        = idx_q;
    assign campaign_done  = cdone_q;
    assign pass_count     = pass_q;

endmodule
